seq_nr_divider: RTL and testbench



---
 rtl/seq_nr_divider_if.sv | 29 ++
 rtl/seq_nr_divider.sv | 165 ++++++++++++++++
 tb/tb_seq_nr_divider.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seq_nr_divider_if.sv
// seq_nr_divider_if: request/result bundle for the sequential divider.
// Handshake: the master raises start with dividend/divisor valid; the slave
// accepts it only while idle (busy low, state_dbg == 0). After acceptance
// busy stays high until the edge at which done pulses for one cycle.
// quotient/remainder/div_zero are valid from the done cycle and held until
// the next accepted start.
interface seq_nr_divider_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic [1:0]       state_dbg;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, state_dbg
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, state_dbg
  );
endinterface

// File: rtl/seq_nr_divider.sv
// seq_nr_divider: sequential non-restoring unsigned divider, one add/subtract
// row per clock, followed by a single remainder-correction step.
// Optional macro SEQ_DIV_ZERO_CHECK_EN: a zero divisor short-circuits to the
// result-commit step and raises div_zero; without it div_zero is tied low and
// a zero divisor runs the full sequence (quotient all ones, remainder dividend).
module seq_nr_divider #(
  parameter int WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_nr_divider_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   shifted_r;
  logic [WIDTH:0]   row_r;
  logic [WIDTH:0]   fix_r;

`ifdef SEQ_DIV_ZERO_CHECK_EN
  logic dz_q, dz_d;
  logic div_zero_q, div_zero_d;
  logic zero_div;
  assign zero_div = (bus.divisor == '0);
`endif

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef SEQ_DIV_ZERO_CHECK_EN
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  // Next state: accept in IDLE, WIDTH rows in ITER, one commit cycle in FIX.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
`ifdef SEQ_DIV_ZERO_CHECK_EN
          state_d = zero_div ? S_FIX : S_ITER;
`else
          state_d = S_ITER;
`endif
        end
      end
      S_ITER:  if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one non-restoring row, final correction.
  always_comb begin
    d_ext     = {1'b0, d_q};
    shifted_r = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    // Sign of the previous partial remainder picks subtract vs add.
    row_r     = r_q[WIDTH] ? (shifted_r + d_ext) : (shifted_r - d_ext);
    fix_r     = r_q[WIDTH] ? (r_q + d_ext) : r_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          r_d   = '0;
          q_d   = bus.dividend;
          d_d   = bus.divisor;
          cnt_d = '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
          dz_d = zero_div;
          // Preload the known answer so the FIX commit needs no special case.
          if (zero_div) begin
            q_d = '1;
            r_d = {1'b0, bus.dividend};
          end
`endif
        end
      end
      S_ITER: begin
        r_d   = row_r;
        q_d   = {q_q[WIDTH-2:0], ~row_r[WIDTH]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        r_d    = fix_r;
        quot_d = q_q;
        rem_d  = fix_r[WIDTH-1:0];
`ifdef SEQ_DIV_ZERO_CHECK_EN
        div_zero_d = dz_q;
`endif
      end
      default: ;
    endcase
  end

  // Outputs: busy whenever the next state is not IDLE; done follows FIX.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIX);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.state_dbg = state_q;
`ifdef SEQ_DIV_ZERO_CHECK_EN
  assign bus.div_zero  = div_zero_q;
`else
  assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_nr_divider.sv
// tb_seq_nr_divider: directed bench for seq_nr_divider (WIDTH=6 instance)
// plus a reference-model sweep on a WIDTH=8 instance.
module tb_seq_nr_divider;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [11:0] exp_q[$];

  seq_nr_divider_if #(.WIDTH(6)) bus6 ();
  seq_nr_divider_if #(.WIDTH(8)) bus8 ();

  seq_nr_divider #(.WIDTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
  seq_nr_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Runs one operation on the WIDTH=6 instance; called at a negedge, returns
  // at the negedge where done is seen (so a back-to-back start can follow).
  task automatic run_op(input logic [5:0] dvd, input logic [5:0] dvs,
                        input logic [5:0] eq, input logic [5:0] er,
                        input logic edz, input int lat, input bit poke);
    int p;
    bit busy_ok;
    logic [11:0] e;
    bus6.start    = 1'b1;
    bus6.dividend = dvd;
    bus6.divisor  = dvs;
    exp_q.push_back({eq, er});
    @(negedge clk);
    bus6.start    = 1'b0;
    bus6.dividend = ~dvd;
    bus6.divisor  = dvs + 6'd1;
    check("busy_after_start", bus6.busy, 1);
    p = 0;
    busy_ok = 1'b1;
    while (!bus6.done && p < 40) begin
      if (!bus6.busy) busy_ok = 1'b0;
      if (poke && p == 2) begin
        bus6.start    = 1'b1;
        bus6.dividend = 6'd1;
        bus6.divisor  = 6'd1;
      end else begin
        bus6.start = 1'b0;
      end
      @(negedge clk);
      p++;
    end
    bus6.start = 1'b0;
    e = exp_q.pop_front();
    check("done_seen", bus6.done, 1);
    check("latency", p, lat);
    check("busy_during_op", busy_ok, 1);
    check("busy_at_done", bus6.busy, 0);
    check("quotient", bus6.quotient, e[11:6]);
    check("remainder", bus6.remainder, e[5:0]);
    check("div_zero", bus6.div_zero, edz);
  endtask

  task automatic run8(input logic [7:0] dvd, input logic [7:0] dvs);
    int p;
    bus8.start    = 1'b1;
    bus8.dividend = dvd;
    bus8.divisor  = dvs;
    @(negedge clk);
    bus8.start    = 1'b0;
    p = 0;
    while (!bus8.done && p < 40) begin
      @(negedge clk);
      p++;
    end
    check("w8_latency", p, 9);
    check("w8_quotient", bus8.quotient, dvd / dvs);
    check("w8_remainder", bus8.remainder, dvd % dvs);
    @(negedge clk);
  endtask

  // Directed sequence
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus6.start = 1'b0; bus6.dividend = '0; bus6.divisor = '0;
    bus8.start = 1'b0; bus8.dividend = '0; bus8.divisor = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", bus6.busy, 0);
    check("rst_done", bus6.done, 0);
    check("rst_quotient", bus6.quotient, 0);
    check("rst_remainder", bus6.remainder, 0);
    check("rst_div_zero", bus6.div_zero, 0);
    check("rst_state", bus6.state_dbg, 0);
    check("rst_w8_busy", bus8.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, 7, 1'b0);
    @(negedge clk);
    check("done_single_cycle", bus6.done, 0);
    check("quotient_held", bus6.quotient, 6);
    check("state_idle", bus6.state_dbg, 0);

    run_op(6'd63, 6'd1, 6'd63, 6'd0, 1'b0, 7, 1'b0);
    @(negedge clk);
    run_op(6'd5, 6'd9, 6'd0, 6'd5, 1'b0, 7, 1'b0);
    @(negedge clk);

`ifdef SEQ_DIV_ZERO_CHECK_EN
    run_op(6'd37, 6'd0, 6'd63, 6'd37, 1'b1, 1, 1'b0);
`else
    run_op(6'd37, 6'd0, 6'd63, 6'd37, 1'b0, 7, 1'b0);
`endif
    @(negedge clk);

    // Back-to-back: second start held in the done cycle; a poke while busy.
    run_op(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, 7, 1'b0);
    run_op(6'd60, 6'd8, 6'd7, 6'd4, 1'b0, 7, 1'b1);
    @(negedge clk);
    check("poke_ignored_idle", bus6.busy, 0);

    // Asynchronous reset in the middle of an operation.
    bus6.start = 1'b1; bus6.dividend = 6'd45; bus6.divisor = 6'd7;
    @(posedge clk);
    #1 bus6.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus6.busy, 0);
    check("arst_done", bus6.done, 0);
    check("arst_quotient", bus6.quotient, 0);
    check("arst_remainder", bus6.remainder, 0);
    check("arst_div_zero", bus6.div_zero, 0);
    check("arst_state", bus6.state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(6'd20, 6'd3, 6'd6, 6'd2, 1'b0, 7, 1'b0);
    @(negedge clk);

    // WIDTH=8 boundary pairs, then random nonzero-divisor pairs.
    run8(8'd255, 8'd1);
    run8(8'd255, 8'd255);
    run8(8'd0, 8'd5);
    run8(8'd1, 8'd255);
    run8(8'd128, 8'd3);
    for (int i = 0; i < 150; i++) begin
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
